shift_left_pipe: RTL

SHIFT_LEFT_PIPE -- requirements
Module: shift_left_pipe

---
 rtl/shift_left_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/shift_left_pipe.sv
// Lane-granular left shifter (eight 12-bit lanes) with a valid/ready pipeline stage.
// Define SHIFT_LEFT_PIPE_SKID_EN to get a registered in_ready and a one-entry skid register.
module shift_left_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_data,
    input  logic [2:0]  in_shift,
    input  logic [11:0] in_fill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic        out_err,
    output logic [7:0]  err_count
);

    // Handshake: a beat moves on a rising edge where valid and ready are both 1;
    // a producer never withdraws or alters a beat while valid=1 and ready=0.
    logic        accept;
    logic        xfer;
    logic        illegal;
    logic [95:0] shifted;

    assign illegal = (in_shift > 3'd5);
    assign accept  = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;

    always_comb begin
        shifted = '0;
        case (in_shift)
            3'd0:    shifted = in_data;
            3'd1:    shifted = {in_data[83:0], in_fill};
            3'd2:    shifted = {in_data[71:0], {2{in_fill}}};
            3'd3:    shifted = {in_data[59:0], {3{in_fill}}};
            3'd4:    shifted = {in_data[47:0], {4{in_fill}}};
            3'd5:    shifted = {in_data[35:0], {5{in_fill}}};
            default: shifted = '0;
        endcase
    end

    // Counted on acceptance so it reflects commands taken, not results drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (accept && illegal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

`ifdef SHIFT_LEFT_PIPE_SKID_EN

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        ready_q;
    logic [95:0] skid_data;
    logic        skid_err;

    assign in_ready  = ready_q;
    assign out_valid = (state != ST_EMPTY);

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
                if (accept && !xfer)      state_next = ST_TWO;
                else if (!accept && xfer) state_next = ST_EMPTY;
                else                      state_next = ST_ONE;
            end
            ST_TWO:   if (xfer) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // ready_q looks at the next state so it never waits on out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            ready_q   <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != ST_TWO);
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_data <= shifted;
                        out_err  <= illegal;
                    end
                end
                ST_ONE: begin
                    if (accept && !xfer) begin
                        skid_data <= shifted;
                        skid_err  <= illegal;
                    end else if (accept && xfer) begin
                        out_data <= shifted;
                        out_err  <= illegal;
                    end
                end
                ST_TWO: begin
                    if (xfer) begin
                        out_data <= skid_data;
                        out_err  <= skid_err;
                    end
                end
                default: begin
                    out_data <= out_data;
                end
            endcase
        end
    end

`else

    // Held low through reset and released on the first edge afterwards.
    logic run_q;
    logic valid_q;

    assign out_valid = valid_q;
    assign in_ready  = run_q && (!valid_q || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (accept) begin
                valid_q  <= 1'b1;
                out_data <= shifted;
                out_err  <= illegal;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

`endif

endmodule
